// File: rtl/nn_pkg.sv
// Shared constants and encodings for the neural-net datapath blocks.
// Used by the layer-1 weight ROM bank and its fetch controller.
package nn_pkg;

  localparam int WEIGHT_W      = 16;
  localparam int L1_NUM_ROMS   = 28;
  localparam int L1_ROM_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wf_state_t;

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// Control/tag bundle between the weight fetch controller and the layer-1
// sequencer/MAC side.
interface weight_fetch_ctrl_if
  import nn_pkg::*;
#(
  parameter int IDX_W = L1_ROM_ADDR_W
);

  logic             start;
  logic             mac_ready;
  logic             r_en;
  logic             w_valid;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    input  mac_ready,
    output r_en,
    output w_valid,
    output w_idx,
    output w_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    output mac_ready,
    input  r_en,
    input  w_valid,
    input  w_idx,
    input  w_last,
    input  busy,
    input  done
  );

endinterface

// File: rtl/weight_fetch_ctrl_tag_pipe.sv
// DEPTH-stage shift register with synchronous clear; carries word tags
// alongside the ROM read latency.
module tag_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [DEPTH+1];

  assign chain[0] = din;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (clr) begin
          q_reg <= '0;
        end else begin
          q_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = q_reg;
    end
  endgenerate

  assign dout = chain[DEPTH];

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Steps the layer-1 weight ROM bank through one full pass per start pulse,
// tagging each returned word slice with valid/index/last for the MAC array.
module weight_fetch_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_WORDS   = 2 ** L1_ROM_ADDR_W,
  parameter int ROM_LATENCY = 1,
  parameter int IDX_W       = L1_ROM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  weight_fetch_ctrl_if.master bus
);

  localparam int              TAG_W    = IDX_W + 2;
  localparam logic [IDX_W:0]  END_CNT  = (IDX_W+1)'(NUM_WORDS);
  localparam logic [IDX_W:0]  LAST_CNT = (IDX_W+1)'(NUM_WORDS - 1);
  localparam logic [IDX_W:0]  CNT_ONE  = (IDX_W+1)'(1);

  wf_state_t        state_reg;
  logic [IDX_W:0]   issue_cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             r_en_int;
  logic             issue_last;
  logic [IDX_W-1:0] issue_idx;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;
  logic             last_out;

  // Issue only while fetching and the consumer has promised a slot L cycles out.
  assign r_en_int   = (state_reg == FETCH) && bus.mac_ready && (issue_cnt_reg < END_CNT);
  assign issue_last = r_en_int && (issue_cnt_reg == LAST_CNT);
  assign issue_idx  = r_en_int ? issue_cnt_reg[IDX_W-1:0] : '0;
  assign tag_in     = {r_en_int, issue_idx, issue_last};

  tag_pipe #(
    .DEPTH (ROM_LATENCY),
    .WIDTH (TAG_W)
  ) u_tag_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  // Words leave the pipe in issue order, so the last tag emerging means empty next cycle.
  assign last_out = tag_out[TAG_W-1] && tag_out[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg     <= FETCH;
            issue_cnt_reg <= '0;
            busy_reg      <= 1'b1;
          end
        end
        FETCH: begin
          if (r_en_int) begin
            issue_cnt_reg <= issue_cnt_reg + CNT_ONE;
            if (issue_last) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_out) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r_en    = r_en_int;
  assign bus.w_valid = tag_out[TAG_W-1];
  assign bus.w_idx   = tag_out[IDX_W:1];
  assign bus.w_last  = tag_out[0];
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Drives two controllers (ROM latency 1 and 3) with shared stimulus and checks
// each against a cycle-scheduled behavioural model plus a small ROM model.
module tb_weight_fetch_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mac_ready = 1'b0;

  always #5 clk = ~clk;

  weight_fetch_ctrl_if #(.IDX_W(IW)) bus0 ();
  weight_fetch_ctrl_if #(.IDX_W(IW)) bus1 ();

  assign bus0.start     = start;
  assign bus0.mac_ready = mac_ready;
  assign bus1.start     = start;
  assign bus1.mac_ready = mac_ready;

  weight_fetch_ctrl #(.NUM_WORDS(N), .ROM_LATENCY(1), .IDX_W(IW)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  weight_fetch_ctrl #(.NUM_WORDS(N), .ROM_LATENCY(3), .IDX_W(IW)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic          act_ren  [2];
  logic          act_val  [2];
  logic [IW-1:0] act_idx  [2];
  logic          act_last [2];
  logic          act_busy [2];
  logic          act_done [2];

  assign act_ren[0]  = bus0.r_en;
  assign act_val[0]  = bus0.w_valid;
  assign act_idx[0]  = bus0.w_idx;
  assign act_last[0] = bus0.w_last;
  assign act_busy[0] = bus0.busy;
  assign act_done[0] = bus0.done;
  assign act_ren[1]  = bus1.r_en;
  assign act_val[1]  = bus1.w_valid;
  assign act_idx[1]  = bus1.w_idx;
  assign act_last[1] = bus1.w_last;
  assign act_busy[1] = bus1.busy;
  assign act_done[1] = bus1.done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Model: per pass, remember when fetching may begin, how many words were issued,
  // and a ring of future cycles holding the tag each cycle must present.
  bit m_active    [2];
  int m_fetch_from[2];
  int m_issued    [2];
  int m_done_at   [2];
  bit s_val [2][8];
  int s_idx [2][8];
  bit s_last[2][8];

  bit e_ren [2];
  bit e_val [2];
  int e_idx [2];
  bit e_last[2];
  bit e_busy[2];
  bit e_done[2];

  int          rom_ptr [2];
  logic [15:0] rom_ring[2][8];

  int done_cyc[2];
  int done_cnt[2];
  int ren_cnt [2];
  int rise_cyc[2];
  bit prev_val[2];

  localparam int NEVER = 32'h7fff_ffff;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] wmem(input int i);
    return 16'hC300 + 16'(i * 273);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int slot;
      slot      = cyc % 8;
      e_val[k]  = s_val[k][slot];
      e_idx[k]  = s_val[k][slot] ? s_idx[k][slot] : 0;
      e_last[k] = s_val[k][slot] && s_last[k][slot];
      s_val[k][slot]  = 1'b0;
      s_last[k][slot] = 1'b0;
      e_ren[k]  = m_active[k] && (cyc >= m_fetch_from[k]) && (m_issued[k] < N) && mac_ready;
      e_busy[k] = m_active[k] && (cyc >= m_fetch_from[k]) && (cyc < m_done_at[k]);
      e_done[k] = m_active[k] && (cyc == m_done_at[k]);
      if (rst) begin
        m_active[k]  = 1'b0;
        m_done_at[k] = NEVER;
        for (int j = 0; j < 8; j++) begin
          s_val[k][j]  = 1'b0;
          s_last[k][j] = 1'b0;
        end
      end else begin
        if (e_ren[k]) begin
          int ts;
          ts = (cyc + lat(k)) % 8;
          s_val[k][ts]  = 1'b1;
          s_idx[k][ts]  = m_issued[k];
          s_last[k][ts] = (m_issued[k] == N - 1);
          if (m_issued[k] == N - 1) m_done_at[k] = cyc + lat(k) + 1;
          m_issued[k]++;
        end
        if (e_done[k]) begin
          m_active[k] = 1'b0;
        end else if (!m_active[k] && start) begin
          m_active[k]     = 1'b1;
          m_fetch_from[k] = cyc + 1;
          m_issued[k]     = 0;
          m_done_at[k]    = NEVER;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit rdy);
    @(posedge clk);
    #1;
    cyc++;
    rst       = r;
    start     = s;
    mac_ready = rdy;
    model_step();
  endtask

  // Compare process: mid-cycle, after inputs and registered outputs have settled.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("r_en[%0d]", k),    32'(act_ren[k]),  32'(e_ren[k]));
        chk($sformatf("w_valid[%0d]", k), 32'(act_val[k]),  32'(e_val[k]));
        chk($sformatf("w_idx[%0d]", k),   32'(act_idx[k]),  32'(e_idx[k]));
        chk($sformatf("w_last[%0d]", k),  32'(act_last[k]), 32'(e_last[k]));
        chk($sformatf("busy[%0d]", k),    32'(act_busy[k]), 32'(e_busy[k]));
        chk($sformatf("done[%0d]", k),    32'(act_done[k]), 32'(e_done[k]));
        if (act_val[k]) begin
          chk($sformatf("rom_word[%0d]", k), 32'(rom_ring[k][cyc % 8]), 32'(wmem(e_idx[k])));
        end
        if (act_done[k]) begin
          done_cyc[k] = cyc;
          done_cnt[k]++;
        end
        if (act_ren[k]) ren_cnt[k]++;
        if (act_val[k] && !prev_val[k]) rise_cyc[k] = cyc;
        prev_val[k] = act_val[k];
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rom_ptr[k] = 0;
      end else if (act_ren[k] === 1'b1) begin
        rom_ring[k][(cyc + lat(k)) % 8] = wmem(rom_ptr[k]);
        rom_ptr[k] = (rom_ptr[k] + 1) % N;
      end
    end
  end

  initial begin
    int s;
    int d0;
    int d1;
    int r0;
    int r1;
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0; m_done_at[k] = NEVER; m_issued[k] = 0; m_fetch_from[k] = 0;
      rom_ptr[k] = 0; done_cyc[k] = -1; done_cnt[k] = 0; ren_cnt[k] = 0;
      rise_cyc[k] = -1; prev_val[k] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        s_val[k][j] = 1'b0; s_last[k][j] = 1'b0; s_idx[k][j] = 0; rom_ring[k][j] = '0;
      end
    end

    repeat (2) step(1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // Unstalled pass.
    s = cyc + 1; r0 = ren_cnt[0]; r1 = ren_cnt[1];
    step(1'b0, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    chk("pin_l1_done_lat",  32'(done_cyc[0] - s), 32'd6);
    chk("pin_l3_done_lat",  32'(done_cyc[1] - s), 32'd8);
    chk("pin_l1_valid_lat", 32'(rise_cyc[0] - s), 32'd2);
    chk("pin_l3_valid_lat", 32'(rise_cyc[1] - s), 32'd4);
    chk("pin_l1_ren_cnt",   32'(ren_cnt[0] - r0), 32'd4);
    chk("pin_l3_ren_cnt",   32'(ren_cnt[1] - r1), 32'd4);

    // Stall: mac_ready low in cycles 2-3 of the pass.
    s = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    chk("pin_l1_stall_done", 32'(done_cyc[0] - s), 32'd8);
    chk("pin_l3_stall_done", 32'(done_cyc[1] - s), 32'd10);

    // Back-to-back: second start on the cycle after done for L=1 (DRAIN for L=3).
    s = cyc + 1; d0 = done_cnt[0]; d1 = done_cnt[1];
    step(1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b0, 1'b1);
    chk("pin_b2b_l1_dones", 32'(done_cnt[0] - d0), 32'd2);
    chk("pin_b2b_l1_last",  32'(done_cyc[0] - s), 32'd13);
    chk("pin_b2b_l3_dones", 32'(done_cnt[1] - d1), 32'd1);

    // Ignored starts in FETCH, DRAIN and DONE.
    s = cyc + 1; d0 = done_cnt[0]; d1 = done_cnt[1]; r0 = ren_cnt[0]; r1 = ren_cnt[1];
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i == 0) || (i == 2) || (i == 5) || (i == 6), 1'b1);
    end
    chk("pin_ign_l1_dones", 32'(done_cnt[0] - d0), 32'd1);
    chk("pin_ign_l3_dones", 32'(done_cnt[1] - d1), 32'd1);
    chk("pin_ign_l1_ren",   32'(ren_cnt[0] - r0), 32'd4);
    chk("pin_ign_l3_ren",   32'(ren_cnt[1] - r1), 32'd4);

    // Mid-pass reset at cycle 3, then a fresh pass.
    d0 = done_cnt[0]; d1 = done_cnt[1];
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("pin_rst_ren",   32'(act_ren[0]), 32'd0);
    chk("pin_rst_busy",  32'(act_busy[1]), 32'd0);
    chk("pin_rst_valid", 32'(act_val[1]), 32'd0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    chk("pin_rst_no_done_l1", 32'(done_cnt[0] - d0), 32'd0);
    chk("pin_rst_no_done_l3", 32'(done_cnt[1] - d1), 32'd0);
    s = cyc + 1;
    step(1'b0, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    chk("pin_after_rst_done", 32'(done_cyc[0] - s), 32'd6);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 250) == 0, ($urandom % 5) == 0, ($urandom % 4) != 0);
    end
    repeat (20) step(1'b0, 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Sequencer for the layer-1 weight ROM bank. On a `start` pulse it steps all 28 weight ROMs in lockstep through one full pass of `NUM_WORDS` entries. It drives the shared `r_en` and tags each returned 28×16-bit word slice with `w_valid`, `w_idx` and `w_last` for the layer-1 MAC array. It honours a downstream `mac_ready` throttle and reports `busy`/`done` to the layer sequencer.

## Interface
- `NUM_WORDS`, default 4: entries per ROM, equal to 2^ROM address width.
- `ROM_LATENCY`, default 1: cycles from an `r_en` assertion until the ROM `data_out` holds that word; legal range 1–3.
- `IDX_W`, default 2: width of `w_idx`; must satisfy 2^IDX_W ≥ `NUM_WORDS`.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset. It is also wired to the ROM bank so the ROMs' internal read pointers return to entry 0.
- `start` input 1: single-cycle request to fetch one full pass. Ignored unless the block is in IDLE.
- `mac_ready` input 1: the consumer can take a word `ROM_LATENCY` cycles from now.
- `r_en` output 1: read enable to every ROM in the bank. Each asserted cycle advances all ROM pointers by one.
- `w_valid` output 1: the ROM `data_out1..28` buses hold a valid word this cycle.
- `w_idx` output IDX_W: entry index of the word currently flagged by `w_valid`.
- `w_last` output 1: qualifies `w_valid` for entry `NUM_WORDS-1`.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse when the last word has been presented.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH → DRAIN when the issue counter reaches `NUM_WORDS`.
  - DRAIN → DONE when the in-flight pipe is empty.
  - DONE → IDLE unconditionally after one cycle.
- `r_en = (state==FETCH) && mac_ready && (issue_cnt < NUM_WORDS)`. It is never asserted in IDLE, DRAIN or DONE, so ROM pointers advance exactly `NUM_WORDS` times per pass. That is a full wrap, so the next pass starts again at entry 0.
- `issue_cnt` (width IDX_W+1) clears on entering FETCH and increments on every `r_en`.
- In-flight tracking is a `ROM_LATENCY`-deep shift pipe of {valid, idx, last}, loaded on `r_en` with {1, `issue_cnt[IDX_W-1:0]`, `issue_cnt==NUM_WORDS-1`}. The pipe outputs drive `w_valid`, `w_idx` and `w_last` directly.
- `mac_ready` low stalls issue only. Words already in flight still emerge. The consumer contract is that `mac_ready` high in cycle t guarantees acceptance in cycle t+`ROM_LATENCY`. There is no skid buffer.
- `done` is asserted in the DONE state, which is the cycle after `w_last`. `busy` is high in FETCH and DRAIN.
- `start` while not in IDLE: ignored, with no queuing.
- `start` in the same cycle as DONE: ignored. The earliest accepted `start` is the cycle after `done`.
- Reset values: state = IDLE, `issue_cnt` = 0, pipe cleared. The outputs `r_en`, `w_valid`, `w_idx`, `w_last`, `busy` and `done` are all 0.
- Reset mid-pass: everything returns to IDLE within one cycle and no `done` is produced. The ROMs share `rst`, so pointer alignment is preserved.

## Timing
- Accept `start` at cycle 0. FETCH begins at cycle 1, and the first `r_en` is in cycle 1 if `mac_ready` is high.
- Unstalled pass: `r_en` is high in cycles 1..`NUM_WORDS`, and `w_valid` is high in cycles 1+L..`NUM_WORDS`+L, where L = `ROM_LATENCY`.
- `done` fires at cycle `NUM_WORDS`+L+1.
- The total is `NUM_WORDS`+L+2 cycles from `start` to IDLE, plus one cycle per stalled FETCH cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `start` to an output. The only combinational input-to-output path is `mac_ready` → `r_en`, and it exists by design.

## Structure
- Shared package `nn_pkg` holds:
  - the constants `WEIGHT_W`=16, `L1_NUM_ROMS`=28 and `L1_ROM_ADDR_W`=2;
  - the FSM state encoding typedef `wf_state_t` (IDLE, FETCH, DRAIN, DONE).
- One sub-module is natural: `tag_pipe`. It is a parameterised depth×width shift register with synchronous clear that carries the {valid, idx, last} tags.
- The layer-1 wrapper, not this block, instantiates the ROM bank and this controller side by side.

## Test plan
- **Reset then unstalled pass, L=1, `mac_ready`=1.** `start` at cycle 0 produces:
  - `r_en` high in cycles 1–4;
  - `w_valid` high in cycles 2–5 with `w_idx` 0, 1, 2, 3;
  - `w_last` high in cycle 5 only;
  - `done` in cycle 6;
  - ROM outputs matching `weights*.mem` entries 0–3.
- **Stall.** Hold `mac_ready` low in cycles 2–3. `r_en` gaps in those cycles, `w_valid` gaps in cycles 3–4, all four indices still arrive in order, and `done` shifts to cycle 8.
- **Back-to-back passes.** Pulse `start` again on the cycle after `done`. The second pass returns entry 0 data again, which proves the ROM pointer wrap.
- **Ignored starts.** `start` pulses during FETCH, DRAIN and DONE produce no extra `r_en` and only one `done`.
- **Mid-pass reset.** Assert `rst` in cycle 3 of a pass. The next cycle shows all outputs at 0 and no `done`. A fresh pass then returns entry 0 first.
- **Latency parameter, L=3.** `w_valid` lags `r_en` by exactly 3 cycles, and `done` arrives at cycle 8.
